rcv_control: RTL and testbench
==============================

RCV_CONTROL -- requirements
Module: rcv_control

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, number of synchronizer flops on serial_in (legal range 2..4).
REQ-002 SHALL have port clk  input  1  system clock; all state updates on the rising edge.
REQ-003 SHALL have port n_rst  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port serial_in  input  1  asynchronous UART line; idle level 1.
REQ-005 SHALL have port packet_done  input  1  one-cycle pulse from the bit timer when the final bit period (stop bit) completes.
REQ-006 SHALL have port stop_bit  input  1  sampled stop bit from the receive shift register, valid in the cycle after packet_done.
REQ-007 SHALL have port data_read  input  1  consumer acknowledge; level-sampled every cycle.
REQ-008 SHALL have port enable_timer  output  1  count enable to the bit timer.
REQ-009 SHALL have port load_buffer  output  1  one-cycle pulse that copies the shift register into the RX data buffer.
REQ-010 SHALL have port data_ready  output  1  buffer holds unread data.
REQ-011 SHALL have port overrun_error  output  1  a packet was loaded over unread data.
REQ-012 SHALL have port framing_error  output  1  the last packet had stop_bit = 0.
REQ-013 SHALL have port start_detected  output  1  one-cycle pulse on an accepted start edge.

Function
REQ-014 serial_in SHALL pass through SYNC_STAGES flops, then one edge-history flop; all reset to 1.
REQ-015 A start edge SHALL be history = 1 and synchronized = 0 in the same cycle.
REQ-016 The FSM SHALL have states IDLE, START, RECEIVE, STOP_CHECK, LOAD.
REQ-017 IDLE: on a start edge, the FSM SHALL go to START and pulse start_detected in that same cycle (combinational from the edge); otherwise it SHALL stay in IDLE.
REQ-018 Start edges outside IDLE SHALL be ignored and SHALL NOT pulse start_detected.
REQ-019 START SHALL last exactly 1 cycle with enable_timer = 0, then go to RECEIVE.
REQ-020 RECEIVE: enable_timer SHALL be 1; on packet_done = 1 the FSM SHALL go to STOP_CHECK.
REQ-021 enable_timer SHALL be 1 only in RECEIVE (Moore output).
REQ-022 STOP_CHECK (1 cycle): stop_bit = 1 SHALL go to LOAD; stop_bit = 0 SHALL set framing_error and go to IDLE, with no load_buffer.
REQ-023 LOAD (1 cycle): load_buffer SHALL be 1, then the FSM SHALL go to IDLE.
REQ-024 data_ready SHALL be set on the cycle after load_buffer.
REQ-025 data_ready SHALL clear on the cycle after data_read = 1 while load_buffer = 0.
REQ-026 When load_buffer and data_read coincide, data_ready SHALL end set.
REQ-027 overrun_error SHALL be set on the cycle after load_buffer = 1 while data_ready = 1 and data_read = 0.
REQ-028 overrun_error SHALL clear on the cycle after data_read = 1 with no coincident load_buffer.
REQ-029 When a set condition and a clear condition for overrun_error coincide, set SHALL win.
REQ-030 framing_error SHALL remain set until the next accepted start edge, and SHALL clear on the cycle after that edge.
REQ-031 A stuck-low line SHALL produce exactly one start edge; further packets SHALL require a 1 then 0 transition.
REQ-032 serial_in low to start_detected SHALL be SYNC_STAGES cycles.
REQ-033 packet_done in LOAD or STOP_CHECK SHALL be ignored.

Reset
REQ-034 While n_rst = 0, the FSM SHALL be IDLE and all synchronizer and history flops SHALL be 1, independent of clk.
REQ-035 While n_rst = 0, enable_timer, load_buffer, data_ready, overrun_error, framing_error and start_detected SHALL all be 0.
REQ-036 Reset asserted mid-packet SHALL abort the packet; after release the block SHALL wait for a fresh 1 to 0 edge.

Verification
REQ-037 Idle line, then serial_in = 0 (SYNC_STAGES = 2): start_detected SHALL pulse 2 cycles later, enable_timer SHALL rise 2 cycles after that, and no other outputs SHALL change.
REQ-038 Good packet: packet_done pulse, then stop_bit = 1: the FSM SHALL take 1 cycle in STOP_CHECK and load_buffer SHALL be 1 for exactly 1 cycle. data_ready SHALL be 1 the cycle after load_buffer; data_read for 1 cycle SHALL clear it the cycle after that.
REQ-039 Bad stop (stop_bit = 0): framing_error SHALL be 1, load_buffer SHALL stay 0, and data_ready SHALL be unchanged. framing_error SHALL stay 1 through idle and SHALL clear after the next start edge.
REQ-040 Two good packets with no data_read between them: overrun_error SHALL be 1 after the second load_buffer and data_ready SHALL stay 1. A packet whose load_buffer coincides with data_read SHALL leave overrun_error = 0.
REQ-041 n_rst pulsed low while in RECEIVE with serial_in = 0: all outputs SHALL be 0 immediately. With serial_in held at 0 after release, no start_detected SHALL occur until serial_in goes 1 then 0.
REQ-042 Glitch: serial_in low for 1 cycle during RECEIVE SHALL have no effect on the state or on any output.

Source files
------------

// File: rtl/rcv_control.sv
// UART receive controller: start-edge detection on a synchronized line, packet
// sequencing against an external bit timer, and data_ready/overrun/framing status.
//
// state      | meaning
// IDLE       | waiting for a 1->0 edge on the synchronized line
// START      | one-cycle pause before the bit timer is enabled
// RECEIVE    | bit timer running, waiting for packet_done
// STOP_CHECK | sampling stop_bit from the shift register
// LOAD       | copying the shift register into the RX buffer
module rcv_control #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic n_rst,
  input  logic serial_in,
  input  logic packet_done,
  input  logic stop_bit,
  input  logic data_read,
  output logic enable_timer,
  output logic load_buffer,
  output logic data_ready,
  output logic overrun_error,
  output logic framing_error,
  output logic start_detected
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    RECEIVE,
    STOP_CHECK,
    LOAD
  } state_t;

  state_t state;

  logic [SYNC_STAGES-1:0] sync;
  logic [SYNC_STAGES-1:0] qual;
  logic                   history;
  logic                   armed;
  logic                   line;
  logic                   start_edge;

  assign line = sync[SYNC_STAGES-1];

  // The chain resets to 1, so a line held low through reset would look like an
  // edge once it propagates. Edges only count after a real 1 has been seen.
  assign start_edge = armed & history & ~line;

  assign start_detected = (state == IDLE) & start_edge;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sync    <= '1;
      qual    <= '0;
      history <= 1'b1;
      armed   <= 1'b0;
    end else begin
      sync    <= {sync[SYNC_STAGES-2:0], serial_in};
      qual    <= {qual[SYNC_STAGES-2:0], 1'b1};
      history <= line;
      if (qual[SYNC_STAGES-1] && line) armed <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state         <= IDLE;
      enable_timer  <= 1'b0;
      load_buffer   <= 1'b0;
      data_ready    <= 1'b0;
      overrun_error <= 1'b0;
      framing_error <= 1'b0;
    end else begin
      enable_timer <= 1'b0;
      load_buffer  <= 1'b0;
      case (state)
        IDLE: begin
          if (start_edge) begin
            state         <= START;
            framing_error <= 1'b0;
          end
        end
        START: begin
          state        <= RECEIVE;
          enable_timer <= 1'b1;
        end
        RECEIVE: begin
          if (packet_done) state <= STOP_CHECK;
          else enable_timer <= 1'b1;
        end
        STOP_CHECK: begin
          if (stop_bit) begin
            state       <= LOAD;
            load_buffer <= 1'b1;
          end else begin
            state         <= IDLE;
            framing_error <= 1'b1;
          end
        end
        LOAD:    state <= IDLE;
        default: state <= IDLE;
      endcase

      // A load always leaves data_ready set, even when a read coincides.
      if (load_buffer) data_ready <= 1'b1;
      else if (data_read) data_ready <= 1'b0;

      if (load_buffer && data_ready && !data_read) overrun_error <= 1'b1;
      else if (data_read && !load_buffer) overrun_error <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rcv_control.sv
// Scoreboard bench for rcv_control: expected output vectors are queued per cycle
// as stimulus is driven and compared when that cycle is sampled.
module tb_rcv_control;

  logic clk;
  logic n_rst;
  logic serial_in;
  logic packet_done;
  logic stop_bit;
  logic data_read;
  logic enable_timer;
  logic load_buffer;
  logic data_ready;
  logic overrun_error;
  logic framing_error;
  logic start_detected;

  rcv_control #(.SYNC_STAGES(2)) dut (
    .clk(clk),
    .n_rst(n_rst),
    .serial_in(serial_in),
    .packet_done(packet_done),
    .stop_bit(stop_bit),
    .data_read(data_read),
    .enable_timer(enable_timer),
    .load_buffer(load_buffer),
    .data_ready(data_ready),
    .overrun_error(overrun_error),
    .framing_error(framing_error),
    .start_detected(start_detected)
  );

  typedef struct {
    int         cyc;
    string      tag;
    logic [5:0] exp;
  } sb_t;

  sb_t sb[$];
  int  cyc = 0;
  int  n_tests = 0;
  int  n_fail = 0;
  bit  dr_s = 0;
  bit  ov_s = 0;
  bit  fe_s = 0;

  logic [5:0] outv;
  assign outv = {enable_timer, load_buffer, data_ready, overrun_error, framing_error, start_detected};

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // {enable_timer, load_buffer, data_ready, overrun_error, framing_error, start_detected}
  function automatic logic [5:0] v(input bit en, input bit lb, input bit sd);
    return {en, lb, dr_s, ov_s, fe_s, sd};
  endfunction

  task automatic push(input string tag, input int dc, input logic [5:0] e);
    sb.push_back('{cyc + dc, tag, e});
  endtask

  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc == cyc) begin
        check(sb[i].tag, outv, sb[i].exp);
        sb.delete(i);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) push("idle", k, v(0, 0, 0));
    step(n);
  endtask

  task automatic do_read();
    data_read = 1'b1;
    push("read_hold", 0, v(0, 0, 0));
    step(1);
    data_read = 1'b0;
    dr_s = 0;
    ov_s = 0;
    push("read_clr", 0, v(0, 0, 0));
    step(1);
  endtask

  // Full packet with a one-cycle glitch during RECEIVE and packet_done held
  // into STOP_CHECK, both of which must be ignored.
  task automatic run_packet(input bit stop, input bit rd);
    serial_in = 1'b0;
    push("sync_wait", 1, v(0, 0, 0));
    push("start_det", 2, v(0, 0, 1));
    fe_s = 0;
    push("start_state", 3, v(0, 0, 0));
    for (int k = 4; k <= 8; k++) push("receive", k, v(1, 0, 0));
    step(4);
    serial_in = 1'b1;
    step(1);
    serial_in = 1'b0;
    step(1);
    serial_in = 1'b1;
    step(2);
    packet_done = 1'b1;
    push("stop_check", 1, v(0, 0, 0));
    step(1);
    stop_bit = stop;
    step(1);
    packet_done = 1'b0;
    stop_bit = 1'b0;
    if (stop) begin
      push("load", 0, v(0, 1, 0));
      data_read = rd;
      if (dr_s && !rd) ov_s = 1;
      dr_s = 1;
      push("post_load", 1, v(0, 0, 0));
      step(1);
      data_read = 1'b0;
      step(1);
    end else begin
      fe_s = 1;
      push("frame_err", 0, v(0, 0, 0));
      step(1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    n_rst = 1'b0;
    serial_in = 1'b1;
    packet_done = 1'b0;
    stop_bit = 1'b0;
    data_read = 1'b0;
    #3;
    check("rst_init", outv, 6'b0);
    step(3);
    check("rst_hold", outv, 6'b0);
    n_rst = 1'b1;
    idle(6);

    run_packet(1, 0);
    idle(2);
    do_read();
    run_packet(0, 0);
    idle(3);
    run_packet(1, 0);
    idle(2);
    run_packet(1, 0);
    idle(2);
    do_read();
    run_packet(1, 0);
    idle(2);
    run_packet(1, 1);
    idle(2);
    run_packet(0, 0);
    idle(2);

    // Reset mid-RECEIVE with the line held low, then a stuck-low line.
    serial_in = 1'b0;
    push("rst_pre_det", 2, v(0, 0, 1));
    fe_s = 0;
    push("rst_pre_recv", 4, v(1, 0, 0));
    step(5);
    n_rst = 1'b0;
    #1;
    check("rst_mid", outv, 6'b0);
    dr_s = 0;
    ov_s = 0;
    fe_s = 0;
    step(2);
    check("rst_mid_hold", outv, 6'b0);
    n_rst = 1'b1;
    for (int k = 0; k < 8; k++) push("stuck_low", k, 6'b0);
    step(8);
    serial_in = 1'b1;
    idle(4);
    run_packet(1, 0);
    idle(2);

    for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
    check("sb_drain", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
